crc_calc: RTL

CRC_CALC -- requirements
Module: crc_calc

---
 rtl/crc_calc.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/crc_calc.sv
// rtl/crc_calc.sv - byte-serial CRC-16 engine, nibble per cycle, with finalize/compare (optional CRC_FINAL_XOR_EN)
module crc_calc #(
   parameter logic [15:0] POLY = 16'h1021,
   parameter logic [15:0] INIT = 16'hFFFF
) (
   input  logic        clk50m,
   input  logic        rst_n,
   input  logic        crc_clr,
   input  logic        crc_en,
   input  logic [7:0]  data_in,
   input  logic        crc_rdy,
   input  logic [15:0] crc_ref,
   output logic        busy,
   output logic [15:0] crc_out,
   output logic        res_valid,
   output logic        crc_ok,
   output logic        overrun
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] SHIFT_HI = 3'd1;
   localparam logic [2:0] SHIFT_LO = 3'd2;
   localparam logic [2:0] FINAL    = 3'd3;
   localparam logic [2:0] RESULT   = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [15:0] crc_reg_q, crc_reg_d;
   logic [7:0]  byte_q, byte_d;
   logic [15:0] crc_out_q, crc_out_d;
   logic        res_valid_q, res_valid_d;
   logic        crc_ok_q, crc_ok_d;
   logic        overrun_q, overrun_d;
   logic        pend_q, pend_d;
   logic        rdy_q, rdy_d;
   logic        rdy_rise;
   logic [15:0] fin_val;

   // Fold four data bits into the CRC, MSB first, non-reflected.
   function automatic logic [15:0] fold4(input logic [15:0] c, input logic [3:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 3; i >= 0; i--) begin
         if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ POLY;
         else              r = {r[14:0], 1'b0};
      end
      return r;
   endfunction

   assign rdy_rise = crc_rdy & ~rdy_q;

`ifdef CRC_FINAL_XOR_EN
   assign fin_val = crc_reg_q ^ 16'hFFFF;
`else
   assign fin_val = crc_reg_q;
`endif

   // Next-state logic: clear has priority, then per-state sequencing.
   always_comb begin
      state_d     = state_q;
      crc_reg_d   = crc_reg_q;
      byte_d      = byte_q;
      crc_out_d   = crc_out_q;
      res_valid_d = res_valid_q;
      crc_ok_d    = crc_ok_q;
      overrun_d   = overrun_q;
      pend_d      = pend_q;
      rdy_d       = crc_rdy;
      if (crc_clr) begin
         crc_reg_d   = INIT;
         res_valid_d = 1'b0;
         crc_ok_d    = 1'b0;
         overrun_d   = 1'b0;
         pend_d      = 1'b0;
         state_d     = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (crc_en) begin
                  // byte goes first; a coincident finalize request waits for it
                  byte_d  = data_in;
                  state_d = SHIFT_HI;
                  if (rdy_rise) pend_d = 1'b1;
               end else if (pend_q || rdy_rise) begin
                  state_d = FINAL;
               end
            end
            SHIFT_HI: begin
               crc_reg_d = fold4(crc_reg_q, byte_q[7:4]);
               state_d   = SHIFT_LO;
               if (rdy_rise) pend_d = 1'b1;
               if (crc_en) overrun_d = 1'b1;
            end
            SHIFT_LO: begin
               crc_reg_d = fold4(crc_reg_q, byte_q[3:0]);
               if (rdy_rise) pend_d = 1'b1;
               if (crc_en) overrun_d = 1'b1;
               state_d = (pend_q || rdy_rise) ? FINAL : IDLE;
            end
            FINAL: begin
               crc_out_d   = fin_val;
               crc_ok_d    = (fin_val == crc_ref);
               res_valid_d = 1'b1;
               pend_d      = 1'b0;
               if (crc_en) overrun_d = 1'b1;
               state_d     = RESULT;
            end
            RESULT: begin
               state_d = RESULT;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         crc_reg_q   <= INIT;
         byte_q      <= 8'h00;
         crc_out_q   <= 16'h0000;
         res_valid_q <= 1'b0;
         crc_ok_q    <= 1'b0;
         overrun_q   <= 1'b0;
         pend_q      <= 1'b0;
         rdy_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         crc_reg_q   <= crc_reg_d;
         byte_q      <= byte_d;
         crc_out_q   <= crc_out_d;
         res_valid_q <= res_valid_d;
         crc_ok_q    <= crc_ok_d;
         overrun_q   <= overrun_d;
         pend_q      <= pend_d;
         rdy_q       <= rdy_d;
      end
   end

   assign busy      = (state_q == SHIFT_HI) || (state_q == SHIFT_LO);
   assign crc_out   = crc_out_q;
   assign res_valid = res_valid_q;
   assign crc_ok    = crc_ok_q;
   assign overrun   = overrun_q;

endmodule
